// File: rtl/qei_pkg.sv
// Shared constants, delta encoding and decode helpers for the quadrature encoder slave.
package qei_pkg;

    localparam logic [7:0] ADR_CTRL = 8'h00;
    localparam logic [7:0] ADR_POS  = 8'h04;
    localparam logic [7:0] ADR_VEL  = 8'h08;
    localparam logic [7:0] ADR_WIN  = 8'h0C;
    localparam logic [7:0] ADR_STAT = 8'h10;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_INV      = 1;
    localparam int CTRL_IDXCLR   = 2;
    localparam int CTRL_FILT_LSB = 3;

    localparam int STAT_ERR = 0;
    localparam int STAT_IDX = 1;

    localparam logic [23:0] WIN_RST_DEFAULT = 24'd10000;

    typedef enum logic [1:0] {
        DELTA_ZERO,
        DELTA_PLUS,
        DELTA_MINUS,
        DELTA_ERR
    } delta_e;

    // Position of an {A,B} pair along the forward cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] gray_phase(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic delta_e decode_delta(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        logic [1:0] step;
        step = gray_phase(cur_ab) - gray_phase(prev_ab);
        case (step)
            2'd1:    return DELTA_PLUS;
            2'd3:    return DELTA_MINUS;
            2'd2:    return DELTA_ERR;
            default: return DELTA_ZERO;
        endcase
    endfunction

    // 16-bit signed add of a -1/0/+1 delta, clamped to the int16 range.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] d);
        logic [16:0] s;
        s = {a[15], a} + {{15{d[1]}}, d};
        if (s[16] != s[15]) return s[16] ? 16'h8000 : 16'h7FFF;
        return s[15:0];
    endfunction

endpackage

// File: rtl/qei_filter.sv
// Two-flop synchroniser followed by a stability counter: the output follows the
// synchronised pin only once it has differed for depth+1 consecutive clocks.
module qei_filter #(
    parameter int FILT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pin,
    input  logic [FILT_W-1:0] depth,
    output logic              filt
);

    logic              sync1_q, sync2_q;
    logic              filt_q, filt_d;
    logic [FILT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            // >= keeps a shortened depth from stalling a count already past it
            if (cnt_q >= depth) filt_d = sync2_q;
            else                cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/qei_encoder.sv
// Wishbone quadrature encoder slave: filtered A/B/index decode into a 32-bit
// position and a windowed, saturating 16-bit velocity.
module qei_encoder
    import qei_pkg::*;
#(
    parameter int          FILT_W  = 4,
    parameter logic [23:0] WIN_RST = WIN_RST_DEFAULT
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [15:0] i_wb_adr,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    input  logic        i_qa,
    input  logic        i_qb,
    input  logic        i_idx,
    output logic [31:0] o_pos,
    output logic [15:0] o_vel,
    output logic        o_vel_valid
);

    localparam int CW = 3 + FILT_W;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] ctrl_q, ctrl_d;
    logic [31:0]   pos_q, pos_d;
    logic [15:0]   vel_q, vel_d;
    logic [15:0]   acc_q, acc_d;
    logic [23:0]   win_q, win_d;
    logic [23:0]   win_cnt_q, win_cnt_d;
    logic [1:0]    stat_q, stat_d;
    logic [1:0]    ab_prev_q;
    logic          idx_prev_q;
    logic          vel_valid_q, vel_valid_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [7:0]  adr;
    logic        wb_req, wr_en;
    logic        unused_adr_bits;
    logic [2:0]  pin_raw, pin_filt;
    logic [1:0]  ab_cur;
    delta_e      dec_e;
    logic [1:0]  delta;
    logic        idx_rise;
    logic [23:0] win_eff;
    logic        win_end;
    logic [15:0] acc_sum;
    logic [1:0]  stat_w1c;

    assign adr             = i_wb_adr[7:0];
    assign unused_adr_bits = ^i_wb_adr[15:8];
    assign wb_req          = i_wb_cyc & i_wb_stb & (state_q == ST_IDLE);
    assign wr_en           = wb_req & i_wb_we;

    assign pin_raw = {i_idx, i_qb, i_qa};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_filt
            qei_filter #(.FILT_W(FILT_W)) u_filt (
                .clk   (i_wb_clk),
                .rst_n (i_wb_rst_n),
                .pin   (pin_raw[gi]),
                .depth (ctrl_q[CTRL_FILT_LSB +: FILT_W]),
                .filt  (pin_filt[gi])
            );
        end
    endgenerate

    assign ab_cur   = {pin_filt[0], pin_filt[1]};
    assign dec_e    = decode_delta(ab_prev_q, ab_cur);
    assign idx_rise = pin_filt[2] & ~idx_prev_q;

    always_comb begin
        delta = 2'b00;
        if (ctrl_q[CTRL_EN]) begin
            if (dec_e == DELTA_PLUS)  delta = ctrl_q[CTRL_INV] ? 2'b11 : 2'b01;
            if (dec_e == DELTA_MINUS) delta = ctrl_q[CTRL_INV] ? 2'b01 : 2'b11;
        end
    end

    assign win_eff = (win_q == 24'd0) ? 24'd1 : win_q;
    assign win_end = (win_cnt_q >= win_eff - 24'd1);
    assign acc_sum = sat_add16(acc_q, delta);

    always_comb begin
        win_cnt_d   = win_cnt_q;
        acc_d       = acc_q;
        vel_d       = vel_q;
        vel_valid_d = 1'b0;
        if (ctrl_q[CTRL_EN]) begin
            if (win_end) begin
                vel_d       = acc_sum;
                vel_valid_d = 1'b1;
                acc_d       = '0;
                win_cnt_d   = '0;
            end else begin
                acc_d     = acc_sum;
                win_cnt_d = win_cnt_q + 24'd1;
            end
        end
    end

    // CPU write beats index clear, which beats the decoded step.
    always_comb begin
        pos_d = pos_q + {{30{delta[1]}}, delta};
        if (wr_en && adr == ADR_POS)             pos_d = i_wb_data;
        else if (ctrl_q[CTRL_IDXCLR] && idx_rise) pos_d = '0;
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        win_d    = win_q;
        stat_w1c = 2'b00;
        if (wr_en && adr == ADR_CTRL) ctrl_d   = i_wb_data[CW-1:0];
        if (wr_en && adr == ADR_WIN)  win_d    = i_wb_data[23:0];
        if (wr_en && adr == ADR_STAT) stat_w1c = i_wb_data[1:0];
        stat_d = stat_q & ~stat_w1c;
        stat_d[STAT_ERR] = stat_d[STAT_ERR] | (dec_e == DELTA_ERR);
        stat_d[STAT_IDX] = stat_d[STAT_IDX] | idx_rise;
    end

    always_comb begin
        state_d = wb_req ? ST_ACK : ST_IDLE;
        rdata_d = '0;
        if (wb_req) begin
            case (adr)
                ADR_CTRL: rdata_d = {{(32-CW){1'b0}}, ctrl_q};
                ADR_POS:  rdata_d = pos_q;
                ADR_VEL:  rdata_d = {{16{vel_q[15]}}, vel_q};
                ADR_WIN:  rdata_d = {8'h00, win_q};
                ADR_STAT: rdata_d = {30'd0, stat_q};
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q     <= ST_IDLE;
            ctrl_q      <= '0;
            pos_q       <= '0;
            vel_q       <= '0;
            acc_q       <= '0;
            win_q       <= WIN_RST;
            win_cnt_q   <= '0;
            stat_q      <= '0;
            ab_prev_q   <= 2'b00;
            idx_prev_q  <= 1'b0;
            vel_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            pos_q       <= pos_d;
            vel_q       <= vel_d;
            acc_q       <= acc_d;
            win_q       <= win_d;
            win_cnt_q   <= win_cnt_d;
            stat_q      <= stat_d;
            ab_prev_q   <= ab_cur;
            idx_prev_q  <= pin_filt[2];
            vel_valid_q <= vel_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign o_wb_ack    = (state_q == ST_ACK);
    assign o_wb_data   = rdata_q;
    assign o_pos       = pos_q;
    assign o_vel       = vel_q;
    assign o_vel_valid = vel_valid_q;

endmodule
